// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch PC stage.
//   fetch_state_e  : fetch sequencer state encoding
//   IF_INSTR_BYTES : default sequential PC increment
//   IF_RESET_PC    : default PC loaded on reset
package fetch_pc_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_e;

   localparam int          IF_INSTR_BYTES = 4;
   localparam logic [63:0] IF_RESET_PC    = 64'h0;

endpackage

// File: rtl/fetch_instr_buffer.sv
// One-entry holding register for a fetched instruction and its PC.
//   clock_in, reset_n_in : clock, async active-low reset
//   load, load_data, load_pc : capture a new instruction
//   consume              : decode took the entry
//   flush                : drop the entry (redirect), beats load
//   valid, data, pc      : held entry
module fetch_instr_buffer
   import fetch_pc_unit_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clock_in,
   input  logic                   reset_n_in,
   input  logic                   load,
   input  logic                   consume,
   input  logic                   flush,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic [DATA_WIDTH-1:0]  load_pc,
   output logic                   valid,
   output logic [INSTR_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0]  pc
);

   // Load wins over consume so a same-cycle consume/refill keeps the new entry.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         valid <= 1'b0;
         data  <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         pc    <= load_pc;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC stage: holds the fetch PC, issues one-outstanding fetch requests,
// uses the external IF adder for PC + INSTR_BYTES, buffers one instruction
// for decode and handles redirects by discarding the in-flight response.
//   clock_in, reset_n_in              : clock, async active-low reset
//   adder_a/b_data_out, adder_data_in : external adder operands and sum
//   redirect_valid_in, redirect_pc_in : branch/trap redirect
//   fetch_req_*                       : request to instruction memory
//   fetch_rsp_*                       : response from instruction memory
//   instr_*_out, decode_ready_in      : buffered instruction to decode
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | first cycle out of reset, no request yet
// REQ     | presenting fetch request for pc_q
// WAIT    | request accepted, response will update buffer/PC
// DROP    | request accepted, response must be discarded
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(IF_RESET_PC),
   parameter int                    INSTR_BYTES = IF_INSTR_BYTES
) (
   input  logic                   clock_in,
   input  logic                   reset_n_in,
   output logic [DATA_WIDTH-1:0]  adder_a_data_out,
   output logic [DATA_WIDTH-1:0]  adder_b_data_out,
   input  logic [DATA_WIDTH-1:0]  adder_data_in,
   input  logic                   redirect_valid_in,
   input  logic [DATA_WIDTH-1:0]  redirect_pc_in,
   output logic                   fetch_req_valid_out,
   output logic [DATA_WIDTH-1:0]  fetch_req_addr_out,
   input  logic                   fetch_req_ready_in,
   input  logic                   fetch_rsp_valid_in,
   input  logic [INSTR_WIDTH-1:0] fetch_rsp_data_in,
   output logic                   instr_valid_out,
   output logic [INSTR_WIDTH-1:0] instr_data_out,
   output logic [DATA_WIDTH-1:0]  instr_pc_out,
   input  logic                   decode_ready_in
);

   fetch_state_e          state;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] redirect_pc_aligned;
   logic                  buf_free;
   logic                  buf_consume;
   logic                  req_fire;
   logic                  rsp_take;

   assign adder_a_data_out    = pc_q;
   assign adder_b_data_out    = DATA_WIDTH'(INSTR_BYTES);
   assign fetch_req_addr_out  = pc_q;
   assign redirect_pc_aligned = redirect_pc_in & ~DATA_WIDTH'(3);

   // Requesting only into a free (or draining) buffer guarantees the
   // response always has somewhere to land.
   assign buf_consume         = instr_valid_out && decode_ready_in;
   assign buf_free            = !instr_valid_out || decode_ready_in;
   assign fetch_req_valid_out = (state == ST_REQ) && buf_free;
   assign req_fire            = fetch_req_valid_out && fetch_req_ready_in && !redirect_valid_in;
   assign rsp_take            = (state == ST_WAIT) && fetch_rsp_valid_in && !redirect_valid_in;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state <= ST_IDLE;
         pc_q  <= RESET_PC;
      end else if (redirect_valid_in) begin
         pc_q <= redirect_pc_aligned;
         case (state)
            ST_WAIT, ST_DROP: state <= fetch_rsp_valid_in ? ST_REQ : ST_DROP;
            default:          state <= state;
         endcase
      end else begin
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (req_fire) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (fetch_rsp_valid_in) begin
                  pc_q  <= adder_data_in;
                  state <= ST_REQ;
               end
            end
            ST_DROP: begin
               if (fetch_rsp_valid_in) state <= ST_REQ;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   fetch_instr_buffer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_instr_buffer (
      .clock_in   (clock_in),
      .reset_n_in (reset_n_in),
      .load       (rsp_take),
      .consume    (buf_consume),
      .flush      (redirect_valid_in),
      .load_data  (fetch_rsp_data_in),
      .load_pc    (pc_q),
      .valid      (instr_valid_out),
      .data       (instr_data_out),
      .pc         (instr_pc_out)
   );

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

   logic        clock_in;
   logic        reset_n_in;
   logic [63:0] adder_a_data_out;
   logic [63:0] adder_b_data_out;
   logic [63:0] adder_data_in;
   logic        redirect_valid_in;
   logic [63:0] redirect_pc_in;
   logic        fetch_req_valid_out;
   logic [63:0] fetch_req_addr_out;
   logic        fetch_req_ready_in;
   logic        fetch_rsp_valid_in;
   logic [31:0] fetch_rsp_data_in;
   logic        instr_valid_out;
   logic [31:0] instr_data_out;
   logic [63:0] instr_pc_out;
   logic        decode_ready_in;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_req[$];
   logic [63:0] exp_ipc[$];
   logic [31:0] exp_idata[$];

   int          rsp_delay;
   int          mem_cnt;
   logic        mem_pend;
   logic        mem_acc;
   logic [63:0] mem_acc_addr;
   logic [63:0] mem_addr;

   fetch_pc_unit dut (
      .clock_in            (clock_in),
      .reset_n_in          (reset_n_in),
      .adder_a_data_out    (adder_a_data_out),
      .adder_b_data_out    (adder_b_data_out),
      .adder_data_in       (adder_data_in),
      .redirect_valid_in   (redirect_valid_in),
      .redirect_pc_in      (redirect_pc_in),
      .fetch_req_valid_out (fetch_req_valid_out),
      .fetch_req_addr_out  (fetch_req_addr_out),
      .fetch_req_ready_in  (fetch_req_ready_in),
      .fetch_rsp_valid_in  (fetch_rsp_valid_in),
      .fetch_rsp_data_in   (fetch_rsp_data_in),
      .instr_valid_out     (instr_valid_out),
      .instr_data_out      (instr_data_out),
      .instr_pc_out        (instr_pc_out),
      .decode_ready_in     (decode_ready_in)
   );

   // external IF adder
   assign adder_data_in = adder_a_data_out + adder_b_data_out;

   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   task automatic push_instr(input logic [63:0] pc);
      exp_ipc.push_back(pc);
      exp_idata.push_back(mem_word(pc));
   endtask

   task automatic wait_req_left(input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clock_in);
         #1;
         if (exp_req.size() <= n) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: %0d requests pending, expected %0d", exp_req.size(), n);
   endtask

   task automatic wait_instr_left(input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clock_in);
         #1;
         if (exp_ipc.size() <= n) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL instr_timeout: %0d instrs pending, expected %0d", exp_ipc.size(), n);
   endtask

   // instruction memory: responds rsp_delay cycles after a request is accepted
   initial begin
      fetch_rsp_valid_in = 1'b0;
      fetch_rsp_data_in  = '0;
      mem_pend = 1'b0;
      mem_cnt  = 0;
      mem_addr = '0;
      forever begin
         @(negedge clock_in);
         mem_acc      = (reset_n_in === 1'b1) && fetch_req_valid_out && fetch_req_ready_in
                        && !redirect_valid_in;
         mem_acc_addr = fetch_req_addr_out;
         @(posedge clock_in);
         #1;
         fetch_rsp_valid_in = 1'b0;
         if (mem_acc) begin
            mem_pend = 1'b1;
            mem_cnt  = rsp_delay;
            mem_addr = mem_acc_addr;
         end
         if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               fetch_rsp_valid_in = 1'b1;
               fetch_rsp_data_in  = mem_word(mem_addr);
               mem_pend = 1'b0;
            end
         end
      end
   end

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clock_in);
         if (reset_n_in === 1'b1) begin
            if (fetch_req_valid_out && fetch_req_ready_in && !redirect_valid_in) begin
               if (exp_req.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL req_unexpected: addr 0x%0h issued, none expected", fetch_req_addr_out);
               end else begin
                  chk("req_addr", fetch_req_addr_out, exp_req.pop_front());
               end
            end
            if (instr_valid_out && decode_ready_in) begin
               if (exp_ipc.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL instr_unexpected: pc 0x%0h delivered, none expected", instr_pc_out);
               end else begin
                  chk("instr_pc", instr_pc_out, exp_ipc.pop_front());
                  chk("instr_data", {32'h0, instr_data_out}, {32'h0, exp_idata.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      #150000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n_in         = 1'b0;
      redirect_valid_in  = 1'b0;
      redirect_pc_in     = '0;
      fetch_req_ready_in = 1'b0;
      decode_ready_in    = 1'b1;
      rsp_delay          = 1;

      // reset values
      repeat (3) tick();
      chk("rst_req_valid", {63'h0, fetch_req_valid_out}, 64'h0);
      chk("rst_req_addr", fetch_req_addr_out, 64'h0);
      chk("rst_instr_valid", {63'h0, instr_valid_out}, 64'h0);
      chk("rst_instr_data", {32'h0, instr_data_out}, 64'h0);
      chk("rst_instr_pc", instr_pc_out, 64'h0);
      chk("rst_adder_a", adder_a_data_out, 64'h0);
      chk("rst_adder_b", adder_b_data_out, 64'h4);

      // sequential fetch after reset release
      exp_req.push_back(64'h0);
      exp_req.push_back(64'h4);
      exp_req.push_back(64'h8);
      push_instr(64'h0);
      push_instr(64'h4);
      push_instr(64'h8);
      fetch_req_ready_in = 1'b1;
      reset_n_in = 1'b1;
      wait_req_left(0);
      tick();
      fetch_req_ready_in = 1'b0;
      wait_instr_left(0);

      // decode backpressure holds off the next request
      tick();
      decode_ready_in = 1'b0;
      fetch_req_ready_in = 1'b1;
      exp_req.push_back(64'hC);
      exp_req.push_back(64'h10);
      push_instr(64'hC);
      push_instr(64'h10);
      wait_req_left(1);
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock_in);
         chk("bp_req_valid_low", {63'h0, fetch_req_valid_out}, 64'h0);
         chk("bp_buf_full", {63'h0, instr_valid_out}, 64'h1);
      end
      tick();
      decode_ready_in = 1'b1;
      #1;
      chk("bp_req_same_cycle", {63'h0, fetch_req_valid_out}, 64'h1);
      chk("bp_req_addr", fetch_req_addr_out, 64'h10);
      wait_req_left(0);
      tick();
      fetch_req_ready_in = 1'b0;
      wait_instr_left(0);

      // redirect one cycle before the response
      tick();
      rsp_delay = 3;
      exp_req.push_back(64'h14);
      exp_req.push_back(64'h1000);
      exp_req.push_back(64'h1004);
      push_instr(64'h1000);
      push_instr(64'h1004);
      fetch_req_ready_in = 1'b1;
      wait_req_left(2);
      tick();
      tick();
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 64'h1000;
      tick();
      redirect_valid_in = 1'b0;
      wait_req_left(0);
      tick();
      fetch_req_ready_in = 1'b0;
      wait_instr_left(0);

      // redirect coincident with the response, unaligned target
      tick();
      rsp_delay = 2;
      exp_req.push_back(64'h1008);
      exp_req.push_back(64'h2000);
      exp_req.push_back(64'h2004);
      push_instr(64'h2000);
      push_instr(64'h2004);
      fetch_req_ready_in = 1'b1;
      wait_req_left(2);
      tick();
      tick();
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 64'h2003;
      tick();
      redirect_valid_in = 1'b0;
      wait_req_left(0);
      tick();
      fetch_req_ready_in = 1'b0;
      wait_instr_left(0);

      // PC wraps past the top of the address space
      tick();
      rsp_delay = 1;
      exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_req.push_back(64'h0);
      push_instr(64'hFFFF_FFFF_FFFF_FFFC);
      push_instr(64'h0);
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid_in = 1'b0;
      fetch_req_ready_in = 1'b1;
      wait_req_left(0);
      tick();
      fetch_req_ready_in = 1'b0;
      wait_instr_left(0);

      // async reset while waiting; the late response must be ignored
      tick();
      rsp_delay = 4;
      exp_req.push_back(64'h4);
      fetch_req_ready_in = 1'b1;
      wait_req_left(0);
      tick();
      fetch_req_ready_in = 1'b0;
      #2;
      reset_n_in = 1'b0;
      #1;
      chk("arst_req_valid", {63'h0, fetch_req_valid_out}, 64'h0);
      chk("arst_req_addr", fetch_req_addr_out, 64'h0);
      chk("arst_adder_a", adder_a_data_out, 64'h0);
      chk("arst_instr_valid", {63'h0, instr_valid_out}, 64'h0);
      chk("arst_instr_data", {32'h0, instr_data_out}, 64'h0);
      chk("arst_instr_pc", instr_pc_out, 64'h0);
      tick();
      tick();
      reset_n_in = 1'b1;
      exp_req.push_back(64'h0);
      push_instr(64'h0);
      tick();
      tick();
      fetch_req_ready_in = 1'b1;
      wait_req_left(0);
      tick();
      fetch_req_ready_in = 1'b0;
      wait_instr_left(0);

      repeat (4) tick();
      chk("req_queue_drained", 64'(exp_req.size()), 64'h0);
      chk("instr_queue_drained", 64'(exp_ipc.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
